// File: rtl/apb_rr_pkg.sv
// Shared types and constants for the round-robin APB master.
package apb_rr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

  // Watchdog counter width; at least one bit so a disabled watchdog still elaborates.
  function automatic int wdog_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_rr_master_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping; zero latency.
module rr_arbiter
  import apb_rr_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW-1:0] cand [N];

  for (genvar i = 0; i < N; i++) begin : g_cand
    assign cand[i] = IW'((int'(ptr) + i) % N);
  end

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!valid && req[cand[i]]) begin
        valid = 1'b1;
        idx   = cand[i];
      end
    end
    grant = valid ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/apb_rr_master.sv
// Round-robin APB master: latches the winning client's command, runs SETUP/ACCESS,
// returns done/err pulses combinationally in ACCESS; a watchdog aborts stuck transfers.
module apb_rr_master
  import apb_rr_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        req_rnw_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        req_done_o,
  output logic [NUM_REQ-1:0]        req_err_o,
  output logic [DATA_W-1:0]         req_rdata_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic [ADDR_W-1:0]         paddr_o,
  output logic                      pwrite_o,
  output logic [DATA_W-1:0]         pwdata_o,
  input  logic [DATA_W-1:0]         prdata_i,
  input  logic                      pready_i
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WW = wdog_w(TIMEOUT);

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt_idx;
  logic [WW-1:0] wdog;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]      arb_idx;
  logic               arb_valid;

  logic              sel_rnw;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_access;
  logic              done;
  logic              timeout_hit;
  logic [IW-1:0]     ptr_nxt;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req   (req_i),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (arb_grant[k]) begin
        sel_addr  = req_addr_i[k*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign sel_rnw   = |(req_rnw_i & arb_grant);
  assign in_access = (state == ACCESS);
  assign done      = in_access && pready_i;
  // Abort fires on the last permitted wait cycle, so the bus frees on the next edge.
  assign timeout_hit = (TIMEOUT != 0) && in_access && !pready_i &&
                       (wdog == WW'(TIMEOUT - 1));

  assign req_done_o  = done ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign req_err_o   = timeout_hit ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign req_rdata_o = done ? prdata_i : '0;

  assign ptr_nxt = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_idx   <= '0;
      wdog      <= '0;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      paddr_o   <= '0;
      pwrite_o  <= 1'b0;
      pwdata_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            gnt_idx   <= arb_idx;
            paddr_o   <= sel_addr;
            pwrite_o  <= !sel_rnw;
            pwdata_o  <= sel_wdata;
            psel_o    <= 1'b1;
            penable_o <= 1'b0;
            wdog      <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          penable_o <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (pready_i || timeout_hit) begin
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            ptr       <= ptr_nxt;
            state     <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Round-robin APB master: shares one APB completer (the memory-backed APB slave) among NUM_REQ simple request/done clients.
- Latches the winning client's command and runs a full APB SETUP/ACCESS transfer.
- Returns read data and a one-cycle done pulse to the winner.
- Includes an access watchdog, so a stuck pready cannot hang the bus.

Parameters:
- NUM_REQ, 2, number of requesting clients (2..8).
- ADDR_W, 10, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT, 255, max ACCESS cycles without pready before abort; 0 disables the watchdog.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_i  input  NUM_REQ  per-client request; held high until that client's done/err.
- req_rnw_i  input  NUM_REQ  per-client 1=read, 0=write.
- req_addr_i  input  NUM_REQ*ADDR_W  packed per-client address, client k at [k*ADDR_W +: ADDR_W].
- req_wdata_i  input  NUM_REQ*DATA_W  packed per-client write data.
- req_done_o  output  NUM_REQ  one-hot, one-cycle completion pulse.
- req_err_o  output  NUM_REQ  one-hot, one-cycle timeout-abort pulse.
- req_rdata_o  output  DATA_W  read data, valid with the done pulse of a read.
- psel_o  output  1  APB select.
- penable_o  output  1  APB enable.
- paddr_o  output  ADDR_W  APB address.
- pwrite_o  output  1  APB write.
- pwdata_o  output  DATA_W  APB write data.
- prdata_i  input  DATA_W  APB read data.
- pready_i  input  1  APB ready.

Behaviour:
- Reset (asynchronous, reset=0):
  - Registered outputs clear immediately: psel_o, penable_o, paddr_o, pwrite_o, pwdata_o = 0.
  - State = IDLE; round-robin pointer = 0 (client 0 highest priority); watchdog count = 0.
  - Combinational outputs are 0 because state = IDLE.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req_i bit is set, the arbiter picks the first requesting client at or after the pointer, wrapping around.
  - On the clock edge: latch the grant index, rnw, addr and wdata; drive psel_o=1, penable_o=0; go to SETUP.
  - With no request, stay in IDLE with psel_o=0.
- SETUP: one cycle only; next edge sets penable_o=1 and goes to ACCESS.
- ACCESS:
  - psel_o=1, penable_o=1; paddr, pwrite and pwdata stay stable.
  - If pready_i=1: req_done_o[grant]=1 this cycle, combinationally; req_rdata_o=prdata_i, passed through and meaningful only for reads.
  - Next edge after pready: psel_o=0, penable_o=0, pointer = (grant+1) mod NUM_REQ, state -> IDLE.
  - If pready_i=0: increment watchdog.
  - When TIMEOUT != 0 and watchdog == TIMEOUT-1 with pready_i still 0: req_err_o[grant]=1 this cycle; on the next edge drop psel/penable, advance the pointer, go to IDLE.
- Watchdog clears on every entry to SETUP.
- Outside ACCESS: req_done_o = req_err_o = 0 and req_rdata_o = 0.
- Minimum transfer: request seen in IDLE at cycle 0, SETUP at cycle 1, ACCESS with done at cycle 2. There is at least one IDLE cycle between transfers, so the client sees done and drops req before re-arbitration.
- Boundary conditions:
  - A client that drops req_i mid-transfer does not abort it. The transfer completes and the done pulse is still issued.
  - A client whose inputs change after the grant has no effect, because the command is latched.
  - All clients requesting: strict rotation 0,1,..,NUM_REQ-1,0.
  - A single client requesting continuously is granted every transfer.
  - Pointer wrap: grant NUM_REQ-1 sets pointer to 0.
  - pready_i while not in ACCESS is ignored.
  - Reset mid-ACCESS: bus drops immediately and no done/err pulse is issued.

Decomposition:
- Package apb_rr_pkg:
  - state enum {IDLE, SETUP, ACCESS} as 2-bit logic.
  - Default ADDR_W/DATA_W constants.
  - Function for the watchdog width, $clog2(TIMEOUT+1).
- One sub-module, rr_arbiter:
  - Parameter N; inputs req vector and pointer; outputs one-hot grant, binary index and valid.
  - Purely combinational.
- The top level holds the FSM, latches, pointer and watchdog.

Test Plan:
- Client 0 writes addr 0x010, data 0xDEADBEEF, pready tied 1 -> psel at cycle 1, penable at cycle 2, req_done_o=2'b01 at cycle 2, pwrite=1, paddr=0x010.
- Client 1 reads 0x010 after that write, completer returns 0xDEADBEEF -> req_done_o=2'b10 and req_rdata_o=0xDEADBEEF in the same cycle.
- Both clients hold req for 4 transfers each from reset -> grant order 0,1,0,1,...; no client granted twice in a row while the other waits.
- pready held 0 for 3 ACCESS cycles, then 1 -> psel/penable/paddr stable for all 4 ACCESS cycles; exactly one done pulse.
- TIMEOUT=4, pready never asserted -> req_err_o[grant] pulses in the 4th ACCESS cycle; bus idle next cycle; next client granted.
- Reset driven low during ACCESS -> psel_o/penable_o are 0 before the next edge, no done pulse; after release, pointer=0 and client 0 wins.
